mem_byte_sequencer: RTL and testbench
=====================================

# mem_byte_sequencer

Parametrised multi-beat memory access engine between the 16-bit-class datapath and the byte-wide data memory. It replaces the fixed low/high-byte selection with a sequenced transfer. A word of WORD_WIDTH bits is moved as WORD_WIDTH/BYTE_WIDTH little-endian byte beats, or a single zero-extended byte in byte mode. The block owns the memory address/data/strobe pins during a transfer and reports completion with a one-cycle done pulse.

## Interface
- WORD_WIDTH, 16: datapath word width; must be an integer multiple of BYTE_WIDTH, ratio ≥ 1.
- BYTE_WIDTH, 8: memory data width.
- ADDR_WIDTH, 16: memory address width.
- N (derived), WORD_WIDTH/BYTE_WIDTH: beats per word transfer.

Ports:
- Clock  in  1  single clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- req  in  1  transfer request, sampled only when busy=0.
- we  in  1  1 = store, 0 = load; captured with req.
- size  in  1  1 = full word (N beats), 0 = single byte (1 beat); captured with req.
- addr  in  ADDR_WIDTH  base byte address; captured with req.
- wdata  in  WORD_WIDTH  store data; captured with req.
- busy  out  1  transfer in progress; new req ignored.
- done  out  1  one-cycle completion pulse.
- rdata  out  WORD_WIDTH  assembled load result; valid from the done cycle until the next load completes.
- mem_addr  out  ADDR_WIDTH  memory byte address.
- mem_wdata  out  BYTE_WIDTH  memory write byte.
- mem_cs  out  1  memory select, active-high.
- mem_wr  out  1  1 = write, 0 = read; meaningful only with mem_cs=1.
- mem_rdata  in  BYTE_WIDTH  memory read byte, valid the cycle after a read beat.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On req=1: capture we, size, addr, wdata.
  - Set beat count B = size ? N : 1, beat index i = 0.
  - Go to ISSUE.
- **ISSUE** (one beat per cycle)
  - Drive mem_cs=1, mem_wr=we, mem_addr=base+i, mem_wdata=wdata[i*BYTE_WIDTH +: BYTE_WIDTH].
  - Increment i each cycle.
  - After beat B−1: go to DONE if store, WAIT if load.
- **WAIT** (load only): capture the final byte; mem_cs=0.
- **Load assembly**
  - The byte returned for beat i is written into rdata lane i one cycle after that beat is issued.
  - Lanes ≥ B are cleared to 0, so byte mode zero-extends.
  - rdata updates only on load completion; an external view shows rdata changing exactly at the done cycle.
- **DONE**
  - done=1, busy=0, mem_cs=0.
  - A req sampled in DONE is accepted: go directly to ISSUE with the new capture; otherwise go to IDLE.
- **Address arithmetic:** base+i is computed modulo 2^ADDR_WIDTH; a transfer wraps past the top address to 0 without error.
- **Outputs when not in ISSUE:** mem_cs=0, mem_wr=0, mem_addr and mem_wdata held at 0.
- **Stores:** never modify rdata.
- **Reset:** async assertion (Reset=0) at any time, including mid-transfer, forces:
  - state=IDLE, busy=0, done=0, rdata=0;
  - mem_cs=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - A partial store is not completed or retried. Deassertion is synchronised by design intent: the first acceptable req is the one sampled on the first rising edge after Reset returns high.

## Timing
- Let edge 0 be the edge that samples req.
- busy is high from the cycle after edge 0 through the last ISSUE or WAIT cycle; low in DONE.
- Store:
  - Beats occupy cycles 1..B.
  - done in cycle B+1.
  - Word store with N=2: 3 cycles req-to-done.
- Load:
  - Beats occupy cycles 1..B.
  - WAIT in cycle B+1.
  - done and the new rdata in cycle B+2.
  - Word load with N=2: 4 cycles.
- Back-to-back: a req held high through DONE starts the next transfer with beat 0 in the following cycle. There are no idle cycles between transfers.
- mem_rdata is sampled on the rising edge ending the cycle after each read beat; memory read latency is exactly 1.

## Test plan
- **Reset values:** Reset=0 with random inputs → busy=0, done=0, rdata=0, mem_cs=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- **Word store** (16/8): addr=0x0010, wdata=0xBEEF, we=1, size=1 → writes 0xEF@0x0010 in cycle 1 and 0xBE@0x0011 in cycle 2; done in cycle 3; rdata unchanged.
- **Word load** of the same bytes → read beats in cycles 1–2; done in cycle 4 with rdata=0xBEEF.
- **Byte load:** addr=0x0011, size=0 → one read beat; done in cycle 3 with rdata=0x00BE.
- **Wrap plus back-to-back:**
  - Word store at addr=0xFFFF, wdata=0x1234 → 0x34@0xFFFF, 0x12@0x0000.
  - A load req held through DONE starts in the next cycle and returns 0x1234 from base 0xFFFF.
- **Reset mid-store:**
  - Drop Reset after beat 0 of a word store → all outputs 0 immediately; only byte 0 written.
  - A req after release behaves as the first transfer.

Source files
------------

// File: rtl/mem_byte_sequencer_if.sv
// rtl/mem_byte_sequencer_if.sv - request and byte-memory bus bundle for the byte sequencer
interface mem_byte_sequencer_if #(
    parameter int WORD_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic                  size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] wdata;
    logic                  busy;
    logic                  done;
    logic [WORD_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BYTE_WIDTH-1:0] mem_wdata;
    logic                  mem_cs;
    logic                  mem_wr;
    logic [BYTE_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req, we, size, addr, wdata, mem_rdata,
        output busy, done, rdata, mem_addr, mem_wdata, mem_cs, mem_wr
    );

    modport master (
        output req, we, size, addr, wdata, mem_rdata,
        input  busy, done, rdata, mem_addr, mem_wdata, mem_cs, mem_wr
    );
endinterface

// File: rtl/mem_byte_sequencer.sv
// rtl/mem_byte_sequencer.sv - sequences word loads/stores as little-endian byte beats
module mem_byte_sequencer #(
    parameter int WORD_WIDTH = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    mem_byte_sequencer_if.slave  bus
);
    localparam int N     = WORD_WIDTH / BYTE_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic                  size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  rd_pend_q;
    logic [IDX_W-1:0]      rd_idx_q;
    logic [WORD_WIDTH-1:0] asm_q, asm_d;
    logic [WORD_WIDTH-1:0] rdata_q;
    logic                  accept;
    logic                  last_beat;
    logic                  issuing;
    logic [BYTE_WIDTH-1:0] lane_wdata;

    assign issuing   = (state_q == S_ISSUE);
    assign accept    = bus.req && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_beat = !size_q || (idx_q == IDX_W'(N - 1));

    always_comb begin
        lane_wdata = '0;
        for (int l = 0; l < N; l++) begin
            if (idx_q == IDX_W'(l)) lane_wdata = wdata_q[l*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE:  if (bus.req) state_d = S_ISSUE;
            S_ISSUE: begin
                idx_d = idx_q + 1'b1;
                if (last_beat) state_d = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT:  state_d = S_DONE;
            S_DONE:  state_d = bus.req ? S_ISSUE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            we_d    = bus.we;
            size_d  = bus.size;
            addr_d  = bus.addr;
            wdata_d = bus.wdata;
            idx_d   = '0;
        end
    end

    // Read data lags its beat by one cycle; the last byte lands in WAIT and is folded
    // straight into rdata so the result becomes visible exactly in the DONE cycle.
    always_comb begin
        asm_d = asm_q;
        if (accept) begin
            asm_d = '0;
        end else if (rd_pend_q) begin
            for (int l = 0; l < N; l++) begin
                if (rd_idx_q == IDX_W'(l)) asm_d[l*BYTE_WIDTH +: BYTE_WIDTH] = bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            size_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
            asm_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            rd_pend_q <= issuing && !we_q;
            rd_idx_q  <= idx_q;
            asm_q     <= asm_d;
            if (state_q == S_WAIT) rdata_q <= asm_d;
        end
    end

    assign bus.busy      = issuing || (state_q == S_WAIT);
    assign bus.done      = (state_q == S_DONE);
    assign bus.rdata     = rdata_q;
    assign bus.mem_cs    = issuing;
    assign bus.mem_wr    = issuing && we_q;
    assign bus.mem_addr  = issuing ? (addr_q + ADDR_WIDTH'(idx_q)) : '0;
    assign bus.mem_wdata = issuing ? lane_wdata : '0;
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb/tb_mem_byte_sequencer.sv - directed self-checking bench for mem_byte_sequencer
module tb_mem_byte_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_byte_sequencer_if #(.WORD_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    mem_byte_sequencer #(.WORD_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    // {busy, done, mem_cs, mem_wr, mem_addr, mem_wdata}
    logic [27:0] obs;
    logic [27:0] exp;
    assign obs = {bus.busy, bus.done, bus.mem_cs, bus.mem_wr, bus.mem_addr, bus.mem_wdata};

    task automatic start(input logic we, input logic size, input logic [15:0] a, input logic [15:0] wd);
        bus.req = 1'b1; bus.we = we; bus.size = size; bus.addr = a; bus.wdata = wd;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0; bus.we = $urandom; bus.size = $urandom; bus.addr = $urandom; bus.wdata = $urandom;
    endtask

    task automatic test_reset;
        bus.req = 1'b1; bus.we = $urandom; bus.size = $urandom; bus.addr = $urandom; bus.wdata = $urandom;
        bus.mem_rdata = $urandom;
        repeat (3) @(negedge clk);
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL rst_outs got %h exp %h", obs, exp); end
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h exp 0000", bus.rdata); end
        bus.req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (obs !== exp) begin errors++; $display("FAIL rst_idle got %h exp %h", obs, exp); end
    endtask

    task automatic test_word_store;
        start(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        exp = {4'b1011, 16'h0010, 8'hEF};
        checks++; if (obs !== exp) begin errors++; $display("FAIL st_c1 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b1011, 16'h0011, 8'hBE};
        checks++; if (obs !== exp) begin errors++; $display("FAIL st_c2 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b0100, 16'h0000, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL st_c3 got %h exp %h", obs, exp); end
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL st_rdata got %h exp 0000", bus.rdata); end
        @(negedge clk);
        checks++; if (mem[16'h0010] !== 8'hEF) begin errors++; $display("FAIL st_mem0 got %h exp ef", mem[16'h0010]); end
        checks++; if (mem[16'h0011] !== 8'hBE) begin errors++; $display("FAIL st_mem1 got %h exp be", mem[16'h0011]); end
    endtask

    task automatic test_word_load;
        start(1'b0, 1'b1, 16'h0010, 16'h0000);
        exp = {4'b1010, 16'h0010, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL ld_c1 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b1010, 16'h0011, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL ld_c2 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b1000, 16'h0000, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL ld_c3 got %h exp %h", obs, exp); end
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL ld_early got %h exp 0000", bus.rdata); end
        @(negedge clk);
        exp = {4'b0100, 16'h0000, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL ld_c4 got %h exp %h", obs, exp); end
        checks++; if (bus.rdata !== 16'hBEEF) begin errors++; $display("FAIL ld_rdata got %h exp beef", bus.rdata); end
        @(negedge clk);
    endtask

    task automatic test_byte_load;
        start(1'b0, 1'b0, 16'h0011, 16'h0000);
        exp = {4'b1010, 16'h0011, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL bl_c1 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b1000, 16'h0000, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL bl_c2 got %h exp %h", obs, exp); end
        checks++; if (bus.rdata !== 16'hBEEF) begin errors++; $display("FAIL bl_hold got %h exp beef", bus.rdata); end
        @(negedge clk);
        exp = {4'b0100, 16'h0000, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL bl_c3 got %h exp %h", obs, exp); end
        checks++; if (bus.rdata !== 16'h00BE) begin errors++; $display("FAIL bl_rdata got %h exp 00be", bus.rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        start(1'b1, 1'b1, 16'hFFFF, 16'h1234);
        exp = {4'b1011, 16'hFFFF, 8'h34};
        checks++; if (obs !== exp) begin errors++; $display("FAIL w_c1 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b1011, 16'h0000, 8'h12};
        checks++; if (obs !== exp) begin errors++; $display("FAIL w_c2 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b0100, 16'h0000, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL w_c3 got %h exp %h", obs, exp); end
        checks++; if (bus.rdata !== 16'h00BE) begin errors++; $display("FAIL w_rdata got %h exp 00be", bus.rdata); end
        start(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        exp = {4'b1010, 16'hFFFF, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_c1 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b1010, 16'h0000, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_c2 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b1000, 16'h0000, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_c3 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b0100, 16'h0000, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_c4 got %h exp %h", obs, exp); end
        checks++; if (bus.rdata !== 16'h1234) begin errors++; $display("FAIL b2b_rdata got %h exp 1234", bus.rdata); end
        checks++; if (mem[16'hFFFF] !== 8'h34) begin errors++; $display("FAIL w_memff got %h exp 34", mem[16'hFFFF]); end
        checks++; if (mem[16'h0000] !== 8'h12) begin errors++; $display("FAIL w_mem00 got %h exp 12", mem[16'h0000]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_store;
        start(1'b1, 1'b0, 16'h0021, 16'h77CC);
        exp = {4'b1011, 16'h0021, 8'hCC};
        checks++; if (obs !== exp) begin errors++; $display("FAIL bs_c1 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b0100, 16'h0000, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL bs_c2 got %h exp %h", obs, exp); end
        @(negedge clk);
        start(1'b1, 1'b1, 16'h0020, 16'hA55A);
        exp = {4'b1011, 16'h0020, 8'h5A};
        checks++; if (obs !== exp) begin errors++; $display("FAIL rm_c1 got %h exp %h", obs, exp); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp = '0;
        checks++; if (obs !== exp) begin errors++; $display("FAIL rm_outs got %h exp %h", obs, exp); end
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL rm_rdata got %h exp 0000", bus.rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (mem[16'h0020] !== 8'h5A) begin errors++; $display("FAIL rm_mem0 got %h exp 5a", mem[16'h0020]); end
        checks++; if (mem[16'h0021] !== 8'hCC) begin errors++; $display("FAIL rm_mem1 got %h exp cc", mem[16'h0021]); end
        start(1'b0, 1'b0, 16'h0020, 16'h0000);
        exp = {4'b1010, 16'h0020, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL rr_c1 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b1000, 16'h0000, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL rr_c2 got %h exp %h", obs, exp); end
        @(negedge clk);
        exp = {4'b0100, 16'h0000, 8'h00};
        checks++; if (obs !== exp) begin errors++; $display("FAIL rr_c3 got %h exp %h", obs, exp); end
        checks++; if (bus.rdata !== 16'h005A) begin errors++; $display("FAIL rr_rdata got %h exp 005a", bus.rdata); end
        @(negedge clk);
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 1'b0; bus.addr = '0; bus.wdata = '0;
        test_reset();
        test_word_store();
        test_word_load();
        test_byte_load();
        test_back_to_back();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
